// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite blitter slice.
// Sprite geometry lives here so address generation and coordinate recovery agree.
package sprite_pkg;
    localparam int SPRITE_DIM   = 16;
    localparam int SPRITE_BITS  = $clog2(SPRITE_DIM);
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite ROM read port plus framebuffer pixel valid/ready channel.
// The blitter drives the master side; ROM and framebuffer sit on the slave side.
interface sprite_blitter_if #(
    parameter int PIXEL_W = 8
);
    logic [7:0]         rom_address;
    logic [PIXEL_W-1:0] rom_data;
    logic               pix_valid;
    logic               pix_ready;
    logic [9:0]         pix_row;
    logic [9:0]         pix_column;
    logic [PIXEL_W-1:0] pix_data;

    modport master (
        output rom_address, pix_valid, pix_row, pix_column, pix_data,
        input  rom_data, pix_ready
    );
    modport slave (
        input  rom_address, pix_valid, pix_row, pix_column, pix_data,
        output rom_data, pix_ready
    );
endinterface

// File: rtl/sprite_coord.sv
// Recovers screen row/column from a sprite ROM address and the sprite origin.
// Purely combinational; sums are 11 bits so an origin near the edge never wraps.
module sprite_coord
    import sprite_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic [7:0]  address,
    input  logic [9:0]  rowshift,
    input  logic [9:0]  columnshift,
    output logic [10:0] r,
    output logic [10:0] c,
    output logic        offscreen
);
    // Low address nibble is the row offset, high nibble the column offset.
    assign r = {1'b0, rowshift}    + 11'(address[SPRITE_BITS-1:0]);
    assign c = {1'b0, columnshift} + 11'(address[7:SPRITE_BITS]);
    assign offscreen = (r >= 11'(SCREEN_W)) || (c >= 11'(SCREEN_H));
endmodule

// File: rtl/sprite_blitter.sv
// Walks a 16x16 sprite ROM and emits visible, opaque pixels with screen coords.
// Latency: first pixel valid 3 cycles after start; 3 cycles/emitted, 2 cycles/skipped pixel.
// Backpressure: pixel held stable in EMIT until pix_ready; each stalled cycle adds one cycle.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int                 PIXEL_W     = 8,
    parameter int                 SCREEN_W    = SCREEN_W_DEF,
    parameter int                 SCREEN_H    = SCREEN_H_DEF,
    parameter logic [PIXEL_W-1:0] TRANSPARENT = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [9:0]       rowshift,
    input  logic [9:0]       columnshift,
    output logic             busy,
    output logic             done,
    sprite_blitter_if.master bus
);
    state_e             state_q;
    logic [7:0]         counter_q;
    logic [9:0]         rowshift_q;
    logic [9:0]         columnshift_q;
    logic [9:0]         pix_row_q;
    logic [9:0]         pix_column_q;
    logic [PIXEL_W-1:0] pix_data_q;

    logic [10:0] r;
    logic [10:0] c;
    logic        offscreen;
    logic        skip;
    logic        last;

    sprite_coord #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_coord (
        .address     (counter_q),
        .rowshift    (rowshift_q),
        .columnshift (columnshift_q),
        .r           (r),
        .c           (c),
        .offscreen   (offscreen)
    );

    assign skip = (bus.rom_data == TRANSPARENT) || offscreen;
    assign last = &counter_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            rowshift_q    <= '0;
            columnshift_q <= '0;
            pix_row_q     <= '0;
            pix_column_q  <= '0;
            pix_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rowshift_q    <= rowshift;
                        columnshift_q <= columnshift;
                        counter_q     <= '0;
                        state_q       <= ST_READ;
                    end
                end
                ST_READ: state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (skip) begin
                        if (last) begin
                            state_q <= ST_DONE;
                        end else begin
                            counter_q <= counter_q + 8'd1;
                            state_q   <= ST_READ;
                        end
                    end else begin
                        pix_row_q    <= r[9:0];
                        pix_column_q <= c[9:0];
                        pix_data_q   <= bus.rom_data;
                        state_q      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.pix_ready) begin
                        if (last) begin
                            state_q <= ST_DONE;
                        end else begin
                            counter_q <= counter_q + 8'd1;
                            state_q   <= ST_READ;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign bus.pix_valid   = (state_q == ST_EMIT);
    assign bus.rom_address = counter_q;
    assign bus.pix_row     = pix_row_q;
    assign bus.pix_column  = pix_column_q;
    assign bus.pix_data    = pix_data_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: synchronous ROM model, pixel/timing scoreboard, directed blits.
module tb_sprite_blitter;
    logic       clk;
    logic       reset_n;
    logic       start;
    logic [9:0] rowshift;
    logic [9:0] columnshift;
    logic       busy;
    logic       done;

    sprite_blitter_if #(.PIXEL_W(8)) bus ();

    sprite_blitter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rowshift    (rowshift),
        .columnshift (columnshift),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int row;
        int col;
        int data;
        int cyc;
    } px_t;

    px_t exp_q[$];
    int  exp_done;
    int  total = 0;
    int  bad   = 0;

    bit  active;
    bit  done_seen;
    bit  aborted;
    int  s_cyc;
    int  emit_idx;
    int  stall_pix;
    int  stall_left;
    int  abort_at;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Walk addresses in order: each costs READ+CHECK, an emitted one adds EMIT plus stalls.
    task automatic build_model(input int rs, input int cs, input bit opaque,
                               input int spix, input int sn);
        int t;
        int k;
        exp_q.delete();
        t = 0;
        k = 0;
        for (int a = 0; a < 256; a++) begin
            int r;
            int c;
            int d;
            r = rs + (a % 16);
            c = cs + (a / 16);
            d = opaque ? (a | 1) : 0;
            t += 2;
            if (d != 0 && r < 640 && c < 480) begin
                px_t p;
                t += 1 + ((k == spix) ? sn : 0);
                p.row  = r;
                p.col  = c;
                p.data = d;
                p.cyc  = t;
                exp_q.push_back(p);
                k++;
            end
        end
        exp_done = t + 1;
    endtask

    always @(negedge clk) begin
        if (active) begin
            int rel;
            rel = cyc - s_cyc;
            if (bus.pix_valid && emit_idx == stall_pix && stall_left > 0) begin
                bus.pix_ready = 1'b0;
                stall_left--;
            end else begin
                bus.pix_ready = 1'b1;
            end
            if (abort_at >= 0 && bus.pix_valid && emit_idx == abort_at) begin
                reset_n = 1'b0;
                aborted = 1'b1;
                active  = 1'b0;
            end else begin
                if (rel >= 1 && rel <= exp_done) chk("busy", 32'(busy), 1);
                if (exp_q.size() > 0 && rel == exp_q[0].cyc)
                    chk("pix_valid_at_handshake", 32'(bus.pix_valid), 1);
                if (bus.pix_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("extra_pixel");
                    end else begin
                        chk("pix_row", 32'(bus.pix_row), exp_q[0].row);
                        chk("pix_column", 32'(bus.pix_column), exp_q[0].col);
                        chk("pix_data", 32'(bus.pix_data), exp_q[0].data);
                        if (bus.pix_ready) begin
                            chk("handshake_cycle", rel, exp_q[0].cyc);
                            void'(exp_q.pop_front());
                            emit_idx++;
                        end
                    end
                end
                if (done) begin
                    chk("done_cycle", rel, exp_done);
                    done_seen = 1'b1;
                    active    = 1'b0;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        chk({tag, "_rom_address"}, 32'(bus.rom_address), 0);
        chk({tag, "_pix_row"}, 32'(bus.pix_row), 0);
        chk({tag, "_pix_column"}, 32'(bus.pix_column), 0);
        chk({tag, "_pix_data"}, 32'(bus.pix_data), 0);
    endtask

    task automatic run_blit(input int rs, input int cs, input bit opaque,
                            input int spix, input int sn, input int abort_idx,
                            input bit mid_start, input bit start_at_done);
        for (int a = 0; a < 256; a++) rom[a] = opaque ? 8'(a | 1) : 8'h00;
        build_model(rs, cs, opaque, spix, sn);
        stall_pix     = spix;
        stall_left    = sn;
        abort_at      = abort_idx;
        emit_idx      = 0;
        done_seen     = 1'b0;
        aborted       = 1'b0;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        #2;
        start       = 1'b1;
        rowshift    = 10'(rs);
        columnshift = 10'(cs);
        s_cyc       = cyc;
        active      = 1'b1;
        for (int i = 0; i < 3000 && !done_seen && !aborted; i++) begin
            @(negedge clk);
            #2;
            start = mid_start && (i == 40);
            if (start) begin
                rowshift    = 10'd300;
                columnshift = 10'd200;
            end
        end
        if (aborted) begin
            check_all_zero("async_reset");
            @(negedge clk);
            #2;
            check_all_zero("held_reset");
            reset_n = 1'b1;
            exp_q.delete();
        end else if (!done_seen) begin
            active = 1'b0;
            fail_now("blit_timeout");
        end else begin
            chk("pixels_left", exp_q.size(), 0);
            start       = start_at_done;
            rowshift    = 10'd5;
            columnshift = 10'd5;
            @(negedge clk);
            #2;
            start = 1'b0;
            chk("busy_after_done", 32'(busy), 0);
            chk("done_one_cycle", 32'(done), 0);
            @(negedge clk);
            #2;
            chk("idle_after_done_start", 32'(busy), 0);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        rowshift      = '0;
        columnshift   = '0;
        active        = 1'b0;
        abort_at      = -1;
        stall_pix     = -1;
        stall_left    = 0;
        bus.pix_ready = 1'b1;
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        build_model(0, 0, 1'b1, -1, 0);
        chk("model_opaque_count", exp_q.size(), 256);
        chk("model_opaque_done", exp_done, 769);
        chk("model_opaque_first_hs", exp_q[0].cyc, 3);
        chk("model_px17_row", exp_q[17].row, 1);
        chk("model_px17_col", exp_q[17].col, 1);
        chk("model_px17_data", exp_q[17].data, 17);
        run_blit(0, 0, 1'b1, -1, 0, -1, 1'b0, 1'b1);

        build_model(0, 0, 1'b0, -1, 0);
        chk("model_transparent_count", exp_q.size(), 0);
        chk("model_transparent_done", exp_done, 513);
        run_blit(0, 0, 1'b0, -1, 0, -1, 1'b0, 1'b0);

        build_model(630, 470, 1'b1, -1, 0);
        chk("model_corner_count", exp_q.size(), 100);
        chk("model_corner_first_row", exp_q[0].row, 630);
        chk("model_corner_first_col", exp_q[0].col, 470);
        chk("model_corner_last_row", exp_q[99].row, 639);
        chk("model_corner_last_col", exp_q[99].col, 479);
        chk("model_corner_last_data", exp_q[99].data, 153);
        run_blit(630, 470, 1'b1, -1, 0, -1, 1'b0, 1'b0);

        build_model(0, 0, 1'b1, 0, 5);
        chk("model_stall_first_hs", exp_q[0].cyc, 8);
        chk("model_stall_done", exp_done, 774);
        run_blit(0, 0, 1'b1, 0, 5, -1, 1'b0, 1'b0);

        run_blit(100, 50, 1'b1, -1, 0, -1, 1'b1, 1'b0);

        run_blit(0, 0, 1'b1, -1, 0, 40, 1'b0, 1'b0);
        run_blit(0, 0, 1'b1, -1, 0, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
